// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with log2(WIDTH) levels spread over STAGES registers.
// Define SHIFTER_ROTATE_EN to build the rotate path; without it op 11 decodes as SRL.
module pipelined_shifter #(
  parameter  int WIDTH   = 32,
  parameter  int STAGES  = 2,
  parameter  int TAG_W   = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic advance_s;

  logic [WIDTH-1:0]   data_r  [STAGES];
  logic [TAG_W-1:0]   tag_r   [STAGES];
  logic               valid_r [STAGES];
  logic [SHAMT_W-1:0] shamt_r [STAGES];
  logic               fill_r  [STAGES];
  logic               sll_r   [STAGES];

  logic [WIDTH-1:0]   src_data_s  [STAGES];
  logic [TAG_W-1:0]   src_tag_s   [STAGES];
  logic [SHAMT_W-1:0] src_shamt_s [STAGES];
  logic               src_fill_s  [STAGES];
  logic               src_sll_s   [STAGES];
  logic [WIDTH-1:0]   nxt_data_s  [STAGES];
`ifdef SHIFTER_ROTATE_EN
  logic               rot_r       [STAGES];
  logic               src_rot_s   [STAGES];
`endif

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  // Applies every right-shift level owned by this stage; SLL arrives pre-reversed.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] sh,
    input logic               fill,
`ifdef SHIFTER_ROTATE_EN
    input logic               rot,
`endif
    input int                 stage
  );
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   hi;
    logic [2*WIDTH-1:0] ext;
    r = d;
    for (int k = 0; k < SHAMT_W; k++) begin
`ifdef SHIFTER_ROTATE_EN
      hi = rot ? r : {WIDTH{fill}};
`else
      hi = {WIDTH{fill}};
`endif
      ext = {hi, r};
      r = ((((k * STAGES) / SHAMT_W) == stage) && sh[k]) ? ext[(1 << k) +: WIDTH] : r;
    end
    return r;
  endfunction

  assign advance_s = out_ready | ~valid_r[STAGES-1];
  assign in_ready  = advance_s;
  assign out_valid = valid_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];
  assign out_tag   = tag_r[STAGES-1];

  // Stage operands (port decode for stage 0, previous register otherwise) and their shifted results.
  always_comb begin
    src_data_s[0]  = (in_op == 2'b00) ? bit_reverse(in_data) : in_data;
    src_tag_s[0]   = in_tag;
    src_shamt_s[0] = in_shamt;
    src_fill_s[0]  = (in_op == 2'b10) & in_data[WIDTH-1];
    src_sll_s[0]   = (in_op == 2'b00);
`ifdef SHIFTER_ROTATE_EN
    src_rot_s[0]   = (in_op == 2'b11);
`endif
    for (int s = 1; s < STAGES; s++) begin
      src_data_s[s]  = data_r[s-1];
      src_tag_s[s]   = tag_r[s-1];
      src_shamt_s[s] = shamt_r[s-1];
      src_fill_s[s]  = fill_r[s-1];
      src_sll_s[s]   = sll_r[s-1];
`ifdef SHIFTER_ROTATE_EN
      src_rot_s[s]   = rot_r[s-1];
`endif
    end
    for (int s = 0; s < STAGES; s++) begin
`ifdef SHIFTER_ROTATE_EN
      nxt_data_s[s] = shift_stage(src_data_s[s], src_shamt_s[s], src_fill_s[s], src_rot_s[s], s);
`else
      nxt_data_s[s] = shift_stage(src_data_s[s], src_shamt_s[s], src_fill_s[s], s);
`endif
      nxt_data_s[s] = ((s == STAGES - 1) && src_sll_s[s]) ? bit_reverse(nxt_data_s[s]) : nxt_data_s[s];
    end
  end

  // Datapath registers: cleared by reset, otherwise all stages move together on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        data_r[s]  <= {WIDTH{1'b0}};
        tag_r[s]   <= {TAG_W{1'b0}};
        shamt_r[s] <= {SHAMT_W{1'b0}};
        fill_r[s]  <= 1'b0;
        sll_r[s]   <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
        rot_r[s]   <= 1'b0;
`endif
      end
    end else if (advance_s) begin
      for (int s = 0; s < STAGES; s++) begin
        if ((s != 0) || in_valid) begin
          data_r[s]  <= nxt_data_s[s];
          tag_r[s]   <= src_tag_s[s];
          shamt_r[s] <= src_shamt_s[s];
          fill_r[s]  <= src_fill_s[s];
          sll_r[s]   <= src_sll_s[s];
`ifdef SHIFTER_ROTATE_EN
          rot_r[s]   <= src_rot_s[s];
`endif
        end
      end
    end
  end

  // Valid bits: reset and flush clear every stage, flush winning over advance.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_r[s] <= 1'b0;
      end
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        valid_r[s] <= valid_r[s-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, STAGES=2): directed sweeps, backpressure,
// flush and reset scenarios, then randomized traffic against an arithmetic reference model.
module tb_pipelined_shifter;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]  in_data, out_data;
  logic [4:0]        in_shamt;
  logic [1:0]        in_op;
  logic [TAG_W-1:0]  in_tag, out_tag;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    int               issue;
    int               stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  bit   bp_rand = 1'b0;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a, input int sh, input logic [1:0] op);
    case (op)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: return $unsigned($signed(a) >>> sh);
      default: begin
`ifdef SHIFTER_ROTATE_EN
        if (sh == 0) return a;
        else return (a >> sh) | (a << (WIDTH - sh));
`else
        return a >> sh;
`endif
      end
    endcase
  endfunction

  // Monitor: decides at each negedge what the coming posedge will do and checks outputs.
  initial begin
    bit   hold_pend = 1'b0;
    bit   rst_pend = 1'b0;
    bit   flush_pend = 1'b0;
    bit   adv;
    logic [WIDTH-1:0] hold_d;
    logic [TAG_W-1:0] hold_t;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_pend) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        if (rst_n) chk("rst_in_ready", 64'(in_ready), 64'(1));
      end
      if (flush_pend) chk("flush_out_valid", 64'(out_valid), 64'(0));
      if (hold_pend) begin
        chk("hold_out_valid", 64'(out_valid), 64'(1));
        chk("hold_out_data", 64'(out_data), 64'(hold_d));
        chk("hold_out_tag", 64'(out_tag), 64'(hold_t));
      end
      rst_pend = 1'b0;
      flush_pend = 1'b0;
      hold_pend = 1'b0;
      if (!rst_n) begin
        sb_q.delete();
        rst_pend = 1'b0 | 1'b1;
      end else begin
        adv = out_ready | !out_valid;
        chk("in_ready", 64'(in_ready), 64'(adv));
        if (flush) begin
          sb_q.delete();
          flush_pend = 1'b1;
        end else begin
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_out: got data 0x%0h tag %0d expected no result", out_data, out_tag);
            end else begin
              e = sb_q.pop_front();
              chk("out_data", 64'(out_data), 64'(e.data));
              chk("out_tag", 64'(out_tag), 64'(e.tag));
              chk("latency", 64'(cyc - e.issue), 64'(STAGES + stall_cnt - e.stall));
            end
          end
          if (out_valid && !out_ready) begin
            hold_pend = 1'b1;
            hold_d = out_data;
            hold_t = out_tag;
          end
          if (in_valid && in_ready) begin
            e.data  = ref_shift(in_data, int'(in_shamt), in_op);
            e.tag   = in_tag;
            e.issue = cyc;
            e.stall = stall_cnt;
            sb_q.push_back(e);
          end
          if (!adv) stall_cnt++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [4:0] sh, input logic [1:0] op, input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = a;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected acceptance (tag %0d)", tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_op = 2'b00; in_tag = '0; out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;

    for (int op = 1; op <= 2; op++) begin
      for (int i = 0; i < 32; i++) send(32'h8000_0000, 5'(i), 2'(op), 5'(i));
    end
    send(32'h0000_0001, 5'd31, 2'b00, 5'd1);
    send(32'hFFFF_FFFF, 5'd4, 2'b00, 5'd2);
    send(32'h0000_0001, 5'd1, 2'b11, 5'd3);
    send(32'hF0F0_1234, 5'd31, 2'b11, 5'd4);
    for (int op = 0; op < 4; op++) send($urandom, 5'd0, 2'(op), 5'(op + 8));
    idle(5);

    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);

    send(32'h1234_5678, 5'd3, 2'b01, 5'd10);
    send(32'h8765_4321, 5'd7, 2'b10, 5'd11);
    flush = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd2; in_op = 2'b00; in_tag = 5'd12;
    @(negedge clk);
    chk("flush_pre_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    send(32'hCAFE_F00D, 5'd5, 2'b01, 5'd13);
    idle(6);

    send(32'h0F0F_0F0F, 5'd9, 2'b00, 5'd20);
    send(32'hA5A5_A5A5, 5'd17, 2'b10, 5'd21);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    send(32'h0000_FFFF, 5'd8, 2'b01, 5'd22);
    idle(4);

    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      else
        idle(1);
      out_ready = 1'($urandom_range(0, 1));
    end
    bp_rand = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) idle(1);
    idle(2);
    chk("drain_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
